// File: rtl/jpeg_soc_pkg.sv
// Shared constants and types for the JPEG SoC shared-RAM masters.
//   Memory map of the shared window and the command/status words,
//   status bit positions, and the block fetch engine state encoding.
package jpeg_soc_pkg;

  localparam int unsigned WIDTH       = 32;
  localparam int unsigned MEM_BASE    = 206800;
  localparam int unsigned MEM_WORDS   = 1200;
  localparam int unsigned CTRL_ADDR   = 411698;
  localparam int unsigned STAT_ADDR   = 411699;
  localparam int unsigned BLOCK_WORDS = 64;

  // Largest legal block offset: the block must end inside the window.
  localparam int unsigned MAX_OFF     = MEM_WORDS - BLOCK_WORDS;

  localparam int unsigned OFF_W       = 11;
  localparam int unsigned IDX_W       = 7;

  localparam int unsigned CMD_START   = 31;
  localparam int unsigned ST_DONE     = 31;
  localparam int unsigned ST_ERR      = 30;

  typedef enum logic [2:0] {
    IDLE,
    CLR,
    CLR_CHK,
    FETCH,
    DRAIN,
    STAT_WR,
    STAT_CHK
  } fetch_state_t;

  // Status word posted for the CPU: done flag, error flag, words sent.
  function automatic logic [WIDTH-1:0] status_word(input logic e,
                                                   input logic [IDX_W-1:0] n);
    logic [WIDTH-1:0] s;
    s            = '0;
    s[ST_DONE]   = 1'b1;
    s[ST_ERR]    = e;
    s[IDX_W-1:0] = n;
    return s;
  endfunction

endpackage

// File: rtl/block_fetch_engine.sv
// Block fetch engine: port-2 master of the shared dual-port RAM.
//   Polls the command word, clears it (with read-back retry), streams a
//   64-word block from the shared window over valid/ready, then posts a
//   status word (also with read-back retry).
// Ports:
//   clk, nrst            clock, asynchronous active-low reset
//   mem_addr/wdata/enw   registered RAM port-2 request
//   mem_rdata            RAM read data, combinational from mem_addr
//   px_data/px_valid     block word stream to the DCT stage
//   px_ready             DCT stage accepts the current word
//   busy                 high whenever not IDLE
//   err                  sticky bad-offset flag
module block_fetch_engine
  import jpeg_soc_pkg::*;
(
  input  logic             clk,
  input  logic             nrst,
  output logic [WIDTH-1:0] mem_addr,
  output logic [WIDTH-1:0] mem_wdata,
  output logic             mem_enw,
  input  logic [WIDTH-1:0] mem_rdata,
  output logic [WIDTH-1:0] px_data,
  output logic             px_valid,
  input  logic             px_ready,
  output logic             busy,
  output logic             err
);

  fetch_state_t     r_state;
  logic [OFF_W-1:0] r_off;
  logic [IDX_W-1:0] r_idx;

  logic [OFF_W-1:0] w_cmd_off;
  logic             w_cmd_ok;
  logic             w_load;
  logic             w_last;

  assign w_cmd_off = mem_rdata[OFF_W-1:0];
  assign w_cmd_ok  = (w_cmd_off <= OFF_W'(MAX_OFF));
  // Output register is free when empty or being drained this cycle.
  assign w_load    = !px_valid || px_ready;
  assign w_last    = (r_idx == IDX_W'(BLOCK_WORDS - 1));

  // FSM, address counter and output register.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_state   <= IDLE;
      r_off     <= '0;
      r_idx     <= '0;
      mem_addr  <= WIDTH'(CTRL_ADDR);
      mem_wdata <= '0;
      mem_enw   <= 1'b0;
      px_data   <= '0;
      px_valid  <= 1'b0;
      busy      <= 1'b0;
      err       <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          mem_addr <= WIDTH'(CTRL_ADDR);
          mem_enw  <= 1'b0;
          if (mem_rdata[CMD_START]) begin
            // Every command, good or bad, is cleared first.
            r_idx     <= '0;
            busy      <= 1'b1;
            mem_enw   <= 1'b1;
            mem_wdata <= '0;
            r_state   <= CLR;
            if (w_cmd_ok) begin
              r_off <= w_cmd_off;
              err   <= 1'b0;
            end else begin
              err   <= 1'b1;
            end
          end
        end
        CLR: begin
          mem_enw <= 1'b0;
          r_state <= CLR_CHK;
        end
        CLR_CHK: begin
          if (mem_rdata == '0) begin
            if (err) begin
              r_state   <= STAT_WR;
              mem_addr  <= WIDTH'(STAT_ADDR);
              mem_wdata <= status_word(err, r_idx);
              mem_enw   <= 1'b1;
            end else begin
              r_state   <= FETCH;
              mem_addr  <= WIDTH'(MEM_BASE) + WIDTH'(r_off);
            end
          end else begin
            // Clear lost to a port-1 collision; write it again.
            r_state <= CLR;
            mem_enw <= 1'b1;
          end
        end
        FETCH: begin
          if (w_load) begin
            px_data  <= mem_rdata;
            px_valid <= 1'b1;
            r_idx    <= r_idx + 1'b1;
            // Address holds on the last word so nothing past the block is issued.
            if (w_last) r_state  <= DRAIN;
            else        mem_addr <= mem_addr + WIDTH'(1);
          end
        end
        DRAIN: begin
          if (px_ready) begin
            px_valid  <= 1'b0;
            r_state   <= STAT_WR;
            mem_addr  <= WIDTH'(STAT_ADDR);
            mem_wdata <= status_word(err, r_idx);
            mem_enw   <= 1'b1;
          end
        end
        STAT_WR: begin
          mem_enw <= 1'b0;
          r_state <= STAT_CHK;
        end
        STAT_CHK: begin
          if (mem_rdata == mem_wdata) begin
            r_state  <= IDLE;
            busy     <= 1'b0;
            mem_addr <= WIDTH'(CTRL_ADDR);
          end else begin
            r_state <= STAT_WR;
            mem_enw <= 1'b1;
          end
        end
        default: begin
          r_state  <= IDLE;
          busy     <= 1'b0;
          mem_enw  <= 1'b0;
          mem_addr <= WIDTH'(CTRL_ADDR);
        end
      endcase
    end
  end

endmodule

// File: tb/tb_block_fetch_engine.sv
// Directed bench for block_fetch_engine with a behavioural shared-RAM model.
module tb_block_fetch_engine;
  import jpeg_soc_pkg::*;

  logic        clk = 1'b0;
  logic        nrst;
  logic [31:0] mem_addr, mem_wdata, mem_rdata, px_data;
  logic        mem_enw, px_valid, px_ready, busy, err;

  block_fetch_engine dut (
    .clk       (clk),
    .nrst      (nrst),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_enw   (mem_enw),
    .mem_rdata (mem_rdata),
    .px_data   (px_data),
    .px_valid  (px_valid),
    .px_ready  (px_ready),
    .busy      (busy),
    .err       (err)
  );

  always #5 clk = ~clk;

  // RAM model
  logic [31:0] win [0:1199];
  logic [31:0] ctrl_w, stat_w;
  bit          drop_clr;

  always_comb begin
    if (mem_addr == 32'(CTRL_ADDR))      mem_rdata = ctrl_w;
    else if (mem_addr == 32'(STAT_ADDR)) mem_rdata = stat_w;
    else if (mem_addr >= 32'(MEM_BASE) && mem_addr < 32'(MEM_BASE + MEM_WORDS))
      mem_rdata = win[int'(mem_addr - 32'(MEM_BASE))];
    else mem_rdata = 32'hDEAD_BEEF;
  end

  always @(posedge clk) begin
    if (mem_enw) begin
      if (mem_addr == 32'(CTRL_ADDR)) begin
        if (drop_clr) drop_clr = 1'b0;
        else          ctrl_w   = mem_wdata;
      end else if (mem_addr == 32'(STAT_ADDR)) begin
        stat_w = mem_wdata;
      end
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Ready driver
  bit tog;
  initial begin
    px_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      if (tog) px_ready = ~px_ready;
      else     px_ready = 1'b1;
    end
  end

  // Monitor
  bit          mon_en;
  logic [31:0] got[$];
  int          first_cyc, stall_err, win_err, enw_err;
  logic [31:0] max_addr, prev_data;
  bit          prev_stall;

  always @(negedge clk) begin
    if (nrst && mon_en) begin
      if (px_valid && px_ready) got.push_back(px_data);
      if (px_valid && first_cyc < 0) first_cyc = cyc;
      if (prev_stall && !(px_valid && px_data == prev_data)) stall_err++;
      prev_stall = px_valid && !px_ready;
      prev_data  = px_data;
      if (mem_addr != 32'(CTRL_ADDR) && mem_addr != 32'(STAT_ADDR)) begin
        if (mem_addr < 32'(MEM_BASE) || mem_addr >= 32'(MEM_BASE + MEM_WORDS)) win_err++;
        if (mem_addr > max_addr) max_addr = mem_addr;
        if (mem_enw) enw_err++;
      end
    end
  end

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  typedef struct {
    string       name;
    logic [31:0] cmd;
    bit          tog;
    bit          drop;
    int          exp_beats;
    logic [31:0] exp_stat;
    bit          exp_err;
    int          exp_lat;
    logic [31:0] exp_max;
  } vec_t;

  vec_t vecs[5];

  initial begin
    int          k;
    int          bad;
    int          c0;
    logic [10:0] off;

    vecs[0] = '{"nominal",  32'h8000_0000, 1'b0, 1'b0, 64, 32'h8000_0040, 1'b0, 4, 32'd206863};
    vecs[1] = '{"backpr",   32'h8000_0010, 1'b1, 1'b0, 64, 32'h8000_0040, 1'b0, 4, 32'd206879};
    vecs[2] = '{"badoff",   32'h8000_0471, 1'b0, 1'b0,  0, 32'hC000_0000, 1'b1, 0, 32'd0};
    vecs[3] = '{"dropclr",  32'h8000_0000, 1'b0, 1'b1, 64, 32'h8000_0040, 1'b0, 6, 32'd206863};
    vecs[4] = '{"boundary", 32'h8000_0470, 1'b0, 1'b0, 64, 32'h8000_0040, 1'b0, 4, 32'd207999};

    for (int i = 0; i < 1200; i++) win[i] = 32'(3 * i);
    ctrl_w = '0; stat_w = '0; drop_clr = 1'b0; tog = 1'b0; mon_en = 1'b0;
    first_cyc = -1;

    // Reset values
    nrst = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_addr",  mem_addr, 32'(CTRL_ADDR));
    chk("rst_wdata", mem_wdata, 32'd0);
    chk("rst_ctrl",  {px_valid, mem_enw, busy, err}, 32'd0);
    chk("rst_pxdat", px_data, 32'd0);
    nrst = 1'b1;
    repeat (3) @(negedge clk);
    chk("idle_busy", busy, 32'd0);

    for (int i = 0; i < 5; i++) begin
      got.delete();
      first_cyc = -1; stall_err = 0; win_err = 0; enw_err = 0;
      max_addr = '0; prev_stall = 1'b0;
      stat_w = '0; drop_clr = vecs[i].drop; tog = vecs[i].tog;
      @(posedge clk); #1;
      ctrl_w = vecs[i].cmd;
      c0 = cyc;
      mon_en = 1'b1;
      k = 0;
      while (!busy && k < 20) begin @(negedge clk); k++; end
      while (busy && k < 3000) begin @(negedge clk); k++; end
      chk({vecs[i].name, "_done"}, busy, 32'd0);
      repeat (3) @(negedge clk);
      mon_en = 1'b0;
      tog = 1'b0;

      off = vecs[i].cmd[10:0];
      bad = 0;
      for (int j = 0; j < got.size(); j++)
        if (got[j] !== 32'(3 * (int'(off) + j))) begin
          if (bad == 0)
            $display("FAIL %s_word%0d: got 0x%08h expected 0x%08h", vecs[i].name, j,
                     got[j], 32'(3 * (int'(off) + j)));
          bad++;
        end
      chk({vecs[i].name, "_beats"}, 32'(got.size()), 32'(vecs[i].exp_beats));
      chk({vecs[i].name, "_data"},  32'(bad), 32'd0);
      chk({vecs[i].name, "_ctrl"},  ctrl_w, 32'd0);
      chk({vecs[i].name, "_stat"},  stat_w, vecs[i].exp_stat);
      chk({vecs[i].name, "_err"},   32'(err), 32'(vecs[i].exp_err));
      if (vecs[i].exp_lat > 0)
        chk({vecs[i].name, "_lat"}, 32'(first_cyc - c0), 32'(vecs[i].exp_lat));
      else
        chk({vecs[i].name, "_novalid"}, 32'(first_cyc), 32'hFFFF_FFFF);
      chk({vecs[i].name, "_stall"}, 32'(stall_err), 32'd0);
      chk({vecs[i].name, "_window"}, 32'(win_err), 32'd0);
      chk({vecs[i].name, "_enw"},   32'(enw_err), 32'd0);
      chk({vecs[i].name, "_maxadr"}, max_addr, vecs[i].exp_max);
      chk({vecs[i].name, "_busy"},  32'(busy), 32'd0);
    end

    // Asynchronous reset in the middle of a block
    got.delete(); first_cyc = -1; prev_stall = 1'b0;
    @(posedge clk); #1;
    ctrl_w = 32'h8000_0000;
    mon_en = 1'b1;
    k = 0;
    while (got.size() < 20 && k < 200) begin @(negedge clk); k++; end
    chk("midrst_reach20", 32'(got.size() >= 20), 32'd1);
    #2;
    nrst = 1'b0;
    #1;
    chk("midrst_flags", {px_valid, mem_enw, busy, err}, 32'd0);
    chk("midrst_addr",  mem_addr, 32'd411698);
    mon_en = 1'b0;
    repeat (2) @(negedge clk);
    nrst = 1'b1;
    repeat (5) @(negedge clk);
    chk("postrst_busy", {busy, px_valid}, 32'd0);
    chk("postrst_ctrl", ctrl_w, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
